// File: rtl/qerv_bufreg_seq_if.sv
// Control interface between decode/dbus logic (master) and the bufreg sequencer (slave).
// QERV_SEQ_ABORT_EN adds the i_abort request and the o_trap pulse.
interface qerv_bufreg_seq_if #(
    parameter int unsigned LB = 2
);
    logic          i_start;
    logic          i_two_stage;
    logic          i_mem_op;
    logic          i_shift_op;
    logic [4:0]    i_shamt;
    logic          i_dbus_ack;
`ifdef QERV_SEQ_ABORT_EN
    logic          i_abort;
    logic          o_trap;
`endif
    logic          o_ready;
    logic          o_en;
    logic          o_init;
    logic          o_cnt0;
    logic          o_cnt1;
    logic [LB-1:0] o_shift_counter_lsb;
    logic          o_dbus_cyc;
    logic          o_done;

    modport master (
`ifdef QERV_SEQ_ABORT_EN
        output i_abort,
        input  o_trap,
`endif
        output i_start,
        output i_two_stage,
        output i_mem_op,
        output i_shift_op,
        output i_shamt,
        output i_dbus_ack,
        input  o_ready,
        input  o_en,
        input  o_init,
        input  o_cnt0,
        input  o_cnt1,
        input  o_shift_counter_lsb,
        input  o_dbus_cyc,
        input  o_done
    );

    modport slave (
`ifdef QERV_SEQ_ABORT_EN
        input  i_abort,
        output o_trap,
`endif
        input  i_start,
        input  i_two_stage,
        input  i_mem_op,
        input  i_shift_op,
        input  i_shamt,
        input  i_dbus_ack,
        output o_ready,
        output o_en,
        output o_init,
        output o_cnt0,
        output o_cnt1,
        output o_shift_counter_lsb,
        output o_dbus_cyc,
        output o_done
    );
endinterface

// File: rtl/qerv_bufreg_seq.sv
// Beat sequencer for the nibble-serial bufreg/datapath: INIT, dbus WAIT or nibble SHIFT, RUN, DONE.
// Define QERV_SEQ_ABORT_EN to add i_abort/o_trap (abort of INIT, WAIT or SHIFT).
module qerv_bufreg_seq #(
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter int unsigned W              = 32,
    parameter int unsigned LB             = $clog2(BITS_PER_CYCLE),
    parameter int unsigned CW             = $clog2(W / BITS_PER_CYCLE)
) (
    input logic              i_clk,
    input logic              i_rst_n,
    qerv_bufreg_seq_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StWait,
        StShift,
        StRun,
        StDone
    } state_e;

    // W/BITS_PER_CYCLE is a power of two, so the last beat is all-ones and cnt wraps to 0.
    localparam logic [CW-1:0] LastBeat = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    shamt_q, shamt_d;
    logic          mem_q, mem_d;
    logic          shift_q, shift_d;
    logic [CW-1:0] shift_beats;

`ifdef QERV_SEQ_ABORT_EN
    logic          trap_q, trap_d;
    logic          abort_hit;
`endif

    // Whole-nibble part of the shift amount; the sub-nibble part goes out on o_shift_counter_lsb.
    assign shift_beats = CW'(shamt_q[4:LB]);

`ifdef QERV_SEQ_ABORT_EN
    assign abort_hit = bus.i_abort &&
                       ((state_q == StInit) || (state_q == StWait) || (state_q == StShift));
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shamt_q <= '0;
            mem_q   <= 1'b0;
            shift_q <= 1'b0;
`ifdef QERV_SEQ_ABORT_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shamt_q <= shamt_d;
            mem_q   <= mem_d;
            shift_q <= shift_d;
`ifdef QERV_SEQ_ABORT_EN
            trap_q  <= trap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shamt_d = shamt_q;
        mem_d   = mem_q;
        shift_d = shift_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    shamt_d = bus.i_shamt;
                    mem_d   = bus.i_two_stage & bus.i_mem_op;
                    shift_d = bus.i_two_stage & bus.i_shift_op;
                    cnt_d   = '0;
                    state_d = bus.i_two_stage ? StInit : StRun;
                end
            end
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBeat) begin
                    if (mem_q) begin
                        state_d = StWait;
                    end else if (shift_q && (shift_beats != '0)) begin
                        state_d = StShift;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StWait: begin
                if (bus.i_dbus_ack) begin
                    state_d = StRun;
                end
            end
            StShift: begin
                // cnt counts nibble moves here and restarts at 0 for the RUN phase.
                if (cnt_q == shift_beats - 1'b1) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBeat) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
`ifdef QERV_SEQ_ABORT_EN
        // Abort overrides everything, including a dbus ack in the same cycle.
        trap_d = abort_hit;
        if (abort_hit) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
`endif
    end

    always_comb begin
        bus.o_ready             = 1'b0;
        bus.o_en                = 1'b0;
        bus.o_init              = 1'b0;
        bus.o_cnt0              = 1'b0;
        bus.o_cnt1              = 1'b0;
        bus.o_shift_counter_lsb = '0;
        bus.o_dbus_cyc          = 1'b0;
        bus.o_done              = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.o_ready = 1'b1;
            end
            StInit: begin
                bus.o_en   = 1'b1;
                bus.o_init = 1'b1;
                bus.o_cnt0 = (cnt_q == CW'(0));
                bus.o_cnt1 = (cnt_q == CW'(1));
            end
            StWait: begin
                bus.o_dbus_cyc = 1'b1;
            end
            StShift: begin
                bus.o_en                = 1'b1;
                bus.o_shift_counter_lsb = shift_q ? shamt_q[LB-1:0] : '0;
            end
            StRun: begin
                bus.o_en                = 1'b1;
                bus.o_cnt0              = (cnt_q == CW'(0));
                bus.o_cnt1              = (cnt_q == CW'(1));
                bus.o_shift_counter_lsb = shift_q ? shamt_q[LB-1:0] : '0;
            end
            StDone: begin
                bus.o_done = 1'b1;
            end
            default: begin
                bus.o_ready = 1'b0;
            end
        endcase
    end

`ifdef QERV_SEQ_ABORT_EN
    assign bus.o_trap = trap_q;
`endif

    // Every state drives exactly one of these, so a corrupted state shows up here.
    a_one_phase: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot({bus.o_ready, bus.o_en, bus.o_dbus_cyc, bus.o_done}));
    a_cnt_needs_en: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (bus.o_cnt0 || bus.o_cnt1 || bus.o_init) |-> bus.o_en);

endmodule

// File: tb/tb_qerv_bufreg_seq.sv
// Scoreboard bench for qerv_bufreg_seq: directed ops push expected per-op profiles, a negedge
// monitor measures each op and compares on completion. Define QERV_SEQ_ABORT_EN for the abort case.
module tb_qerv_bufreg_seq;

    localparam int unsigned LB = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    qerv_bufreg_seq_if #(.LB(LB)) bus ();

    qerv_bufreg_seq #(
        .BITS_PER_CYCLE(4),
        .W(32),
        .LB(LB),
        .CW(3)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int lat;
        int en;
        int init;
        int dbus;
        int lsb;
        int cnt0;
        int cnt1;
        int run_cnt0;
        int run_cnt1;
        int trap;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input int lat, input int en, input int init, input int dbus,
                                input int lsb, input int cnt0, input int cnt1,
                                input int run_cnt0, input int run_cnt1, input int trap);
        exp_t e;
        e.lat = lat; e.en = en; e.init = init; e.dbus = dbus; e.lsb = lsb;
        e.cnt0 = cnt0; e.cnt1 = cnt1; e.run_cnt0 = run_cnt0; e.run_cnt1 = run_cnt1;
        e.trap = trap;
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor state.
    bit   active     = 1'b0;
    bit   ready_next = 1'b0;
    int   cyc, n_en, n_init, n_dbus, n_cnt0, n_cnt1, n_overlap, run_cnt0_at, run_cnt1_at, run_lsb;
    logic got_trap;
    exp_t e_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            active     = 1'b0;
            ready_next = 1'b0;
        end else begin
            if (ready_next) begin
                check("ready after done", int'(bus.o_ready), 1);
                ready_next = 1'b0;
            end
            if (active) begin
                cyc++;
                n_en      += int'(bus.o_en);
                n_init    += int'(bus.o_init);
                n_dbus    += int'(bus.o_dbus_cyc);
                n_cnt0    += int'(bus.o_cnt0);
                n_cnt1    += int'(bus.o_cnt1);
                n_overlap += int'(bus.o_en & bus.o_dbus_cyc);
                if (bus.o_cnt0 && !bus.o_init && run_cnt0_at < 0) begin
                    run_cnt0_at = cyc;
                    run_lsb     = int'(bus.o_shift_counter_lsb);
                end
                if (bus.o_cnt1 && !bus.o_init && run_cnt1_at < 0) run_cnt1_at = cyc;
`ifdef QERV_SEQ_ABORT_EN
                got_trap = bus.o_trap;
`else
                got_trap = 1'b0;
`endif
                if (bus.o_done || got_trap || cyc > 60) begin
                    check("expectation queued", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e_mon = exp_q.pop_front();
                        check("latency", cyc, e_mon.lat);
                        check("done pulse", int'(bus.o_done), (e_mon.trap != 0) ? 0 : 1);
                        check("trap pulse", int'(got_trap), e_mon.trap);
                        check("en beats", n_en, e_mon.en);
                        check("init beats", n_init, e_mon.init);
                        check("dbus_cyc cycles", n_dbus, e_mon.dbus);
                        check("en during dbus", n_overlap, 0);
                        check("cnt0 count", n_cnt0, e_mon.cnt0);
                        check("cnt1 count", n_cnt1, e_mon.cnt1);
                        check("run cnt0 cycle", run_cnt0_at, e_mon.run_cnt0);
                        check("run cnt1 cycle", run_cnt1_at, e_mon.run_cnt1);
                        check("shift lsb in run", run_lsb, e_mon.lsb);
                    end
                    active = 1'b0;
                    if (got_trap) check("ready with trap", int'(bus.o_ready), 1);
                    else ready_next = 1'b1;
                end
            end else begin
                if (bus.o_done) check("spurious done", int'(bus.o_done), 0);
                if (bus.o_ready && bus.i_start) begin
                    active      = 1'b1;
                    cyc         = 0;
                    n_en        = 0;
                    n_init      = 0;
                    n_dbus      = 0;
                    n_cnt0      = 0;
                    n_cnt1      = 0;
                    n_overlap   = 0;
                    run_cnt0_at = -1;
                    run_cnt1_at = -1;
                    run_lsb     = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic val, input int budget, input string name);
        int n = 0;
        while (bus.o_ready !== val && n < budget) begin
            tick();
            n++;
        end
        if (bus.o_ready !== val) check({"timeout ", name}, int'(bus.o_ready), int'(val));
    endtask

    task automatic run_op(input logic two, input logic mem, input logic shift,
                          input logic [4:0] shamt, input int ack_delay, input bit abort,
                          input exp_t e);
        int n = 0;
        wait_ready(1'b1, 60, "idle before start");
        exp_q.push_back(e);
        bus.i_two_stage = two;
        bus.i_mem_op    = mem;
        bus.i_shift_op  = shift;
        bus.i_shamt     = shamt;
        bus.i_start     = 1'b1;
        tick();
        bus.i_start     = 1'b0;
        bus.i_two_stage = 1'b0;
        bus.i_mem_op    = 1'b0;
        bus.i_shift_op  = 1'b0;
        bus.i_shamt     = 5'd0;
        if (two && mem) begin
            while (!bus.o_dbus_cyc && n < 20) begin
                tick();
                n++;
            end
            if (!bus.o_dbus_cyc) begin
                check("timeout dbus_cyc", int'(bus.o_dbus_cyc), 1);
            end else begin
                repeat (ack_delay) tick();
                bus.i_dbus_ack = 1'b1;
`ifdef QERV_SEQ_ABORT_EN
                bus.i_abort = abort;
`endif
                tick();
                bus.i_dbus_ack = 1'b0;
`ifdef QERV_SEQ_ABORT_EN
                bus.i_abort = 1'b0;
`endif
            end
        end
        if (abort) tick();
        wait_ready(1'b1, 60, "op completion");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.i_start     = 1'b0;
        bus.i_two_stage = 1'b0;
        bus.i_mem_op    = 1'b0;
        bus.i_shift_op  = 1'b0;
        bus.i_shamt     = 5'd0;
        bus.i_dbus_ack  = 1'b0;
`ifdef QERV_SEQ_ABORT_EN
        bus.i_abort     = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check("reset ready", int'(bus.o_ready), 1);
        check("reset outputs", int'({bus.o_en, bus.o_init, bus.o_cnt0, bus.o_cnt1, bus.o_dbus_cyc,
                                     bus.o_done, bus.o_shift_counter_lsb}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single-stage op; mem/shift flags are ignored without two_stage.
        run_op(1'b0, 1'b0, 1'b0, 5'd0,  0, 1'b0, mk(9, 8, 0, 0, 0, 1, 1, 1, 2, 0));
        run_op(1'b0, 1'b1, 1'b1, 5'd7,  0, 1'b0, mk(9, 8, 0, 0, 0, 1, 1, 1, 2, 0));
        // Shifts: 3 nibble beats + lsb 1; no nibble beats; maximum 7 nibble beats.
        run_op(1'b1, 1'b0, 1'b1, 5'd13, 0, 1'b0, mk(20, 19, 8, 0, 1, 2, 2, 12, 13, 0));
        run_op(1'b1, 1'b0, 1'b1, 5'd3,  0, 1'b0, mk(17, 16, 8, 0, 3, 2, 2, 9, 10, 0));
        run_op(1'b1, 1'b0, 1'b1, 5'd31, 0, 1'b0, mk(24, 23, 8, 0, 3, 2, 2, 16, 17, 0));
        // Two-stage non-shift op: shamt has no effect.
        run_op(1'b1, 1'b0, 1'b0, 5'd20, 0, 1'b0, mk(17, 16, 8, 0, 0, 2, 2, 9, 10, 0));
        // Mem ops: ack 4 cycles after dbus_cyc rises, then ack in the first WAIT cycle.
        run_op(1'b1, 1'b1, 1'b0, 5'd0,  4, 1'b0, mk(22, 16, 8, 5, 0, 2, 2, 14, 15, 0));
        run_op(1'b1, 1'b1, 1'b0, 5'd0,  0, 1'b0, mk(18, 16, 8, 1, 0, 2, 2, 10, 11, 0));

        // Start held high: second op only starts from IDLE after the first completes.
        exp_q.push_back(mk(9, 8, 0, 0, 0, 1, 1, 1, 2, 0));
        exp_q.push_back(mk(9, 8, 0, 0, 0, 1, 1, 1, 2, 0));
        bus.i_start = 1'b1;
        wait_ready(1'b0, 5, "held start accept 1");
        wait_ready(1'b1, 20, "held start idle");
        wait_ready(1'b0, 5, "held start accept 2");
        bus.i_start = 1'b0;
        wait_ready(1'b1, 20, "held start done");

        // Reset during RUN beat 4: immediate idle outputs, no done pulse afterwards.
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (4) tick();
        check("run beat before reset", int'(bus.o_en), 1);
        rst_n = 1'b0;
        #1;
        check("mid reset ready", int'(bus.o_ready), 1);
        check("mid reset outputs", int'({bus.o_en, bus.o_init, bus.o_cnt0, bus.o_cnt1,
                                         bus.o_dbus_cyc, bus.o_done, bus.o_shift_counter_lsb}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        run_op(1'b1, 1'b0, 1'b1, 5'd13, 0, 1'b0, mk(20, 19, 8, 0, 1, 2, 2, 12, 13, 0));

`ifdef QERV_SEQ_ABORT_EN
        // Abort together with ack in the first WAIT cycle: trap, no RUN, no done.
        run_op(1'b1, 1'b1, 1'b0, 5'd0, 0, 1'b1, mk(10, 8, 8, 1, 0, 1, 1, -1, -1, 1));
`endif

        repeat (4) tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
